comm_master: RTL and testbench

- Wireless-link master used by the copter system bench to command the QuadCopter over a UART.
- Sends a 3-byte command frame on TX: cmd, data[15:8], then data[7:0].
- Receives a 1-byte response on RX and holds it with a ready flag until the bench clears it.
- Contains one UART transmitter, one UART receiver and a frame-sequencing FSM.

---
 rtl/comm_master.sv | 250 +++++++++++++++++++++++++
 tb/tb_comm_master.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/comm_master.sv
// UART command master: sends a 3-byte frame (cmd, data hi, data lo) on TX and
// captures single-byte responses from RX with a sticky ready flag.
module comm_master #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        snd_cmd,
  output logic        frm_snt,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy
);

  localparam int unsigned CntW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CntW-1:0] BaudLast = CntW'(BAUD_DIV - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(BAUD_DIV / 2 - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSendHi,
    StSendMid,
    StSendLo,
    StDone
  } frm_state_e;

  frm_state_e state_q, state_d;

  logic [15:0] data_q, data_d;
  logic        frm_snt_q, frm_snt_d;

  logic            tx_q, tx_d;
  logic            tx_busy_q, tx_busy_d;
  logic [9:0]      tx_shift_q, tx_shift_d;
  logic [CntW-1:0] tx_baud_q, tx_baud_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic            tx_load;
  logic [7:0]      tx_byte;
  logic            tx_done;

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic            rx_busy_q, rx_busy_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [3:0]      rx_idx_q, rx_idx_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      resp_q, resp_d;
  logic            resp_rdy_q, resp_rdy_d;
  logic            rx_confirm;
  logic            rx_done;

  assign TX       = tx_q;
  assign frm_snt  = frm_snt_q;
  assign resp     = resp_q;
  assign resp_rdy = resp_rdy_q;

  // Final stop bit of the byte in flight ends on this edge.
  assign tx_done = tx_busy_q && (tx_baud_q == BaudLast) && (tx_bit_q == 4'd9);

  // Frame FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (snd_cmd) state_d = StSendHi;
      StSendHi:  if (tx_done) state_d = StSendMid;
      StSendMid: if (tx_done) state_d = StSendLo;
      StSendLo:  if (tx_done) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Frame FSM: outputs. The cmd byte is loaded straight from the port on the
  // accepting edge so its start bit begins the very next cycle.
  always_comb begin
    tx_load   = 1'b0;
    tx_byte   = cmd;
    data_d    = data_q;
    frm_snt_d = frm_snt_q;
    unique case (state_q)
      StIdle: begin
        if (snd_cmd) begin
          tx_load   = 1'b1;
          tx_byte   = cmd;
          data_d    = data;
          frm_snt_d = 1'b0;
        end
      end
      StSendHi: begin
        if (tx_done) begin
          tx_load = 1'b1;
          tx_byte = data_q[15:8];
        end
      end
      StSendMid: begin
        if (tx_done) begin
          tx_load = 1'b1;
          tx_byte = data_q[7:0];
        end
      end
      StSendLo: begin
        if (tx_done) frm_snt_d = 1'b1;
      end
      StDone: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      frm_snt_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      frm_snt_q <= frm_snt_d;
    end
  end

  // Transmitter: shift_q[0] is always the bit currently on the line.
  always_comb begin
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
    tx_shift_d = tx_shift_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    if (tx_busy_q) begin
      if (tx_baud_q == BaudLast) begin
        tx_baud_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
          tx_d      = 1'b1;
        end else begin
          tx_bit_d   = tx_bit_q + 4'd1;
          tx_shift_d = {1'b1, tx_shift_q[9:1]};
          tx_d       = tx_shift_q[1];
        end
      end else begin
        tx_baud_d = tx_baud_q + CntW'(1);
      end
    end
    // A back-to-back load overrides the idle return, leaving no gap.
    if (tx_load) begin
      tx_shift_d = {1'b1, tx_byte, 1'b0};
      tx_d       = 1'b0;
      tx_busy_d  = 1'b1;
      tx_baud_d  = '0;
      tx_bit_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_shift_q <= '1;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
    end else begin
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
      tx_shift_q <= tx_shift_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
    end
  end

  // Receiver: idx 0 is the start-bit mid check, 1..8 data bits, 9 the stop bit.
  always_comb begin
    rx_busy_d  = rx_busy_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    resp_d     = resp_q;
    rx_confirm = 1'b0;
    rx_done    = 1'b0;
    if (!rx_busy_q) begin
      if (rx_prev_q && !rx_sync_q) begin
        rx_busy_d = 1'b1;
        rx_cnt_d  = HalfLast;
        rx_idx_d  = '0;
      end
    end else if (rx_cnt_q == '0) begin
      rx_cnt_d = BaudLast;
      if (rx_idx_q == 4'd0) begin
        if (rx_sync_q) begin
          rx_busy_d = 1'b0;
        end else begin
          rx_confirm = 1'b1;
          rx_idx_d   = 4'd1;
        end
      end else if (rx_idx_q == 4'd9) begin
        rx_busy_d = 1'b0;
        rx_done   = 1'b1;
        resp_d    = rx_shift_q;
      end else begin
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        rx_idx_d   = rx_idx_q + 4'd1;
      end
    end else begin
      rx_cnt_d = rx_cnt_q - CntW'(1);
    end
  end

  // A start bit only counts as "new" once it survives the mid-point check,
  // so glitches leave the ready flag alone. Completion beats any clear.
  always_comb begin
    resp_rdy_d = resp_rdy_q;
    if (clr_resp_rdy || rx_confirm) resp_rdy_d = 1'b0;
    if (rx_done) resp_rdy_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_busy_q  <= 1'b0;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      resp_q     <= '0;
      resp_rdy_q <= 1'b0;
    end else begin
      rx_meta_q  <= RX;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_busy_q  <= rx_busy_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      resp_q     <= resp_d;
      resp_rdy_q <= resp_rdy_d;
    end
  end

endmodule

// File: tb/tb_comm_master.sv
// Self-checking bench for comm_master: frame bytes and timing on TX, response
// capture on RX, ready-flag priority, glitch rejection and mid-frame reset.
module tb_comm_master;

  localparam int BD = 16;
  // Edges from the bench driving a start bit to the stop-bit sample:
  // two sync flops, one edge-detect edge, half a bit, then nine bit times.
  localparam int RxLat = 3 + BD / 2 + 9 * BD;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        tx;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        snd_cmd;
  logic        frm_snt;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        clr_resp_rdy;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_resp;
  logic       m_rdy;

  always #5 clk = ~clk;

  comm_master #(.BAUD_DIV(BD)) dut (
    .clk         (clk),
    .rst         (rst),
    .RX          (rx),
    .TX          (tx),
    .cmd         (cmd),
    .data        (data),
    .snd_cmd     (snd_cmd),
    .frm_snt     (frm_snt),
    .resp        (resp),
    .resp_rdy    (resp_rdy),
    .clr_resp_rdy(clr_resp_rdy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one frame and checks every bit mid-way through its bit time.
  task automatic send_frame(input logic [7:0] c, input logic [15:0] d, input bit inject);
    logic [7:0] exp_b [3];
    logic [7:0] got_b;
    int pos;
    int target;
    exp_b[0] = c;
    exp_b[1] = d[15:8];
    exp_b[2] = d[7:0];
    cmd = c;
    data = d;
    snd_cmd = 1'b1;
    tick(1);
    snd_cmd = 1'b0;
    cmd = 8'($urandom);
    data = 16'($urandom);
    check("frm_snt_cleared", frm_snt, 0);
    pos = 0;
    for (int k = 0; k < 3; k++) begin
      got_b = '0;
      for (int j = 0; j < 10; j++) begin
        target = (k * 10 + j) * BD + BD / 2;
        tick(target - pos);
        pos = target;
        if (j == 0) check("tx_start_bit", tx, 0);
        else if (j == 9) check("tx_stop_bit", tx, 1);
        else got_b[j-1] = tx;
        if (inject && k == 1 && j == 0) begin
          cmd = 8'h05;
          data = 16'h00FD;
          snd_cmd = 1'b1;
          tick(1);
          pos++;
          snd_cmd = 1'b0;
        end
      end
      check("tx_byte", got_b, exp_b[k]);
    end
    tick(30 * BD - 1 - pos);
    check("frm_snt_early", frm_snt, 0);
    tick(1);
    check("frm_snt_rise", frm_snt, 1);
    check("tx_idle_after", tx, 1);
    tick(2);
  endtask

  // Drives one 8N1 byte on RX; optionally pulses clr in the completion cycle.
  task automatic rx_byte(input logic [7:0] v, input bit clr_at_done);
    logic [9:0] bits;
    bits = {1'b1, v, 1'b0};
    for (int c = 0; c < 10 * BD; c++) begin
      rx = bits[c/BD];
      clr_resp_rdy = clr_at_done && (c == RxLat - 1);
      if (clr_at_done && c == RxLat) begin
        check("set_wins_rdy", resp_rdy, 1);
        check("set_wins_resp", resp, v);
      end
      tick(1);
    end
    rx = 1'b1;
    clr_resp_rdy = 1'b0;
    m_resp = v;
    m_rdy = 1'b1;
  endtask

  initial begin
    logic [7:0]  rc;
    logic [15:0] rd;
    logic [7:0]  rb;
    rst = 1'b1;
    rx = 1'b1;
    cmd = '0;
    data = '0;
    snd_cmd = 1'b0;
    clr_resp_rdy = 1'b0;
    m_resp = 8'h00;
    m_rdy = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(100);
    check("rst_tx", tx, 1);
    check("rst_frm_snt", frm_snt, 0);
    check("rst_resp_rdy", resp_rdy, 0);
    check("rst_resp", resp, 8'h00);

    // First frame with an ignored mid-frame request, then the real second frame.
    send_frame(8'h02, 16'h003A, 1'b1);
    tick(5);
    check("frm_snt_held", frm_snt, 1);
    send_frame(8'h05, 16'h00FD, 1'b0);

    rx_byte(8'hA5, 1'b0);
    check("rx_resp_a5", resp, m_resp);
    check("rx_rdy_a5", resp_rdy, m_rdy);
    clr_resp_rdy = 1'b1;
    tick(1);
    clr_resp_rdy = 1'b0;
    m_rdy = 1'b0;
    check("clr_rdy", resp_rdy, m_rdy);
    check("clr_resp_held", resp, m_resp);

    rx_byte(8'hC0, 1'b1);
    tick(1);
    check("rx_resp_c0", resp, m_resp);
    check("rx_rdy_c0", resp_rdy, m_rdy);

    rx = 1'b0;
    tick(BD / 4);
    rx = 1'b1;
    tick(12 * BD);
    check("glitch_rdy", resp_rdy, m_rdy);
    check("glitch_resp", resp, m_resp);

    // Random frames with a concurrent random response byte.
    for (int i = 0; i < 3; i++) begin
      rc = 8'($urandom);
      rd = 16'($urandom);
      rb = 8'($urandom);
      fork
        send_frame(rc, rd, 1'b0);
        rx_byte(rb, 1'b0);
      join
      check("rand_resp", resp, m_resp);
      check("rand_rdy", resp_rdy, m_rdy);
      if (i < 2) begin
        clr_resp_rdy = 1'b1;
        tick(1);
        clr_resp_rdy = 1'b0;
        m_rdy = 1'b0;
        check("rand_clr", resp_rdy, m_rdy);
      end
    end

    // Reset while TX is in a start bit and RX is mid-start-bit.
    cmd = 8'hFF;
    data = 16'h1234;
    snd_cmd = 1'b1;
    tick(1);
    snd_cmd = 1'b0;
    rx = 1'b0;
    tick(4);
    check("pre_rst_tx_low", tx, 0);
    rst = 1'b1;
    tick(1);
    check("midrst_tx", tx, 1);
    check("midrst_frm_snt", frm_snt, 0);
    check("midrst_rdy", resp_rdy, 0);
    check("midrst_resp", resp, 8'h00);
    rst = 1'b0;
    rx = 1'b1;
    m_resp = 8'h00;
    m_rdy = 1'b0;
    tick(12 * BD);
    check("post_rst_rdy", resp_rdy, m_rdy);
    check("post_rst_resp", resp, m_resp);
    check("post_rst_tx", tx, 1);
    send_frame(8'($urandom), 16'($urandom), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
